spm_seq: RTL and testbench



---
 rtl/spm_seq.sv | 94 +++++++++
 tb/tb_spm_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/spm_seq.sv
// spm_seq: serial-parallel carry-save multiplier with start/busy/done handshake
// Ports: clk, rst (sync, active-high); start, x, y in; busy, p_valid, p_serial,
// done, product (2*WIDTH, held between done pulses) out.
module spm_seq #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               p_valid,
  output logic               p_serial,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int KW = $clog2(2*WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(2*WIDTH-1);
  localparam logic [KW-1:0] K_HI = KW'(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] xr, ysr, s, c, pp, sin, fs, fc;
  logic [KW-1:0] k;
  logic [2*WIDTH-1:0] acc;
  logic ysign, bw, hi, b, d, abit, bit_out, bw_nxt;
  // The array runs an unsigned multiply of x by the sign-extended y stream.
  // For signed x the msb weighs -2^(WIDTH-1), so x_msb*y<<WIDTH is subtracted
  // from the upper product bits by a serial borrow subtractor; y is rotated so
  // its bits come round again for that second half.
  always_comb begin
    hi = k >= K_HI;
    b = hi ? (SIGNED & ysign) : ysr[0];
    pp = xr & {WIDTH{b}};
    sin = {1'b0, s[WIDTH-1:1]};
    fs = pp ^ sin ^ c;
    fc = (pp & sin) | (pp & c) | (sin & c);
    d = SIGNED & hi & xr[WIDTH-1] & ysr[0];
    abit = fs[0];
    bit_out = abit ^ d ^ bw;
    bw_nxt = (~abit & (d | bw)) | (d & bw);
  end
  assign p_serial = p_valid & bit_out;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      p_valid <= 1'b0;
      done <= 1'b0;
      product <= '0;
      xr <= '0;
      ysr <= '0;
      ysign <= 1'b0;
      s <= '0;
      c <= '0;
      bw <= 1'b0;
      k <= '0;
      acc <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          s <= fs;
          c <= fc;
          bw <= bw_nxt;
          k <= k + 1'b1;
          ysr <= {ysr[0], ysr[WIDTH-1:1]};
          acc <= {bit_out, acc[2*WIDTH-1:1]};
          if (k == K_LAST) begin
            product <= {bit_out, acc[2*WIDTH-1:1]};
            state <= DONE;
            busy <= 1'b0;
            p_valid <= 1'b0;
            done <= 1'b1;
          end
        end
        default:
          if (start) begin
            xr <= x;
            ysr <= y;
            ysign <= y[WIDTH-1];
            s <= '0;
            c <= '0;
            bw <= 1'b0;
            k <= '0;
            state <= RUN;
            busy <= 1'b1;
            p_valid <= 1'b1;
          end else
            state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spm_seq.sv
// tb_spm_seq: scoreboard bench for spm_seq at 8-bit unsigned, 8-bit signed and 32-bit unsigned
module tb_spm_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] st = '0;
  logic [31:0] x_in = '0, y_in = '0;
  logic [2:0] busy_v, pv_v, ps_v, done_v;
  logic [15:0] p8u, p8s;
  logic [63:0] p32;
  logic [63:0] prod_v [3];
  typedef struct { int dut; logic [63:0] prod; int t0; } ent_t;
  ent_t sb[$];
  ent_t me;
  int passed = 0, total = 0, cyc = 0;
  logic [63:0] stream [3] = '{default: '0};
  int nb [3] = '{default: 0};
  int wd [3] = '{8, 8, 32};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign prod_v[0] = 64'(p8u);
  assign prod_v[1] = 64'(p8s);
  assign prod_v[2] = p32;

  spm_seq #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .clk(clk), .rst(rst), .start(st[0]), .x(x_in[7:0]), .y(y_in[7:0]),
    .busy(busy_v[0]), .p_valid(pv_v[0]), .p_serial(ps_v[0]), .done(done_v[0]), .product(p8u));
  spm_seq #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .rst(rst), .start(st[1]), .x(x_in[7:0]), .y(y_in[7:0]),
    .busy(busy_v[1]), .p_valid(pv_v[1]), .p_serial(ps_v[1]), .done(done_v[1]), .product(p8s));
  spm_seq #(.WIDTH(32), .SIGNED(1'b0)) u_u32 (
    .clk(clk), .rst(rst), .start(st[2]), .x(x_in), .y(y_in),
    .busy(busy_v[2]), .p_valid(pv_v[2]), .p_serial(ps_v[2]), .done(done_v[2]), .product(p32));

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // monitor: collects serial bits and checks each done against the scoreboard
  always @(negedge clk) begin
    for (int j = 0; j < 3; j++) begin
      if (!rst) begin
        if (!pv_v[j]) chk($sformatf("pserial_quiet_d%0d", j), 64'(ps_v[j]), 64'd0);
        else if (nb[j] < 64) begin
          stream[j][nb[j]] = ps_v[j];
          nb[j]++;
        end
        if (done_v[j]) begin
          if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_done_d%0d: got done with empty scoreboard", j);
          end else begin
            me = sb.pop_front();
            chk("done_dut", 64'(j), 64'(me.dut));
            chk($sformatf("product_d%0d", j), prod_v[j], me.prod);
            chk($sformatf("serial_d%0d", j), stream[j], me.prod);
            chk($sformatf("serial_len_d%0d", j), 64'(nb[j]), 64'(2 * wd[j]));
            chk($sformatf("latency_d%0d", j), 64'(cyc - me.t0), 64'(2 * wd[j] + 1));
            chk($sformatf("done_flags_d%0d", j), {62'd0, busy_v[j], pv_v[j]}, 64'd0);
          end
          nb[j] = 0;
          stream[j] = '0;
        end
      end else begin
        nb[j] = 0;
        stream[j] = '0;
      end
    end
  end

  task automatic wait_done(int j);
    bit seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      seen = done_v[j];
    end
    if (!seen) begin
      total++;
      $display("FAIL done_timeout_d%0d: no done within 300 cycles", j);
    end
  endtask

  task automatic run_op(int j, logic [31:0] xv, logic [31:0] yv, logic [63:0] ev);
    @(posedge clk); #1;
    st[j] = 1'b1;
    x_in = xv;
    y_in = yv;
    sb.push_back('{dut: j, prod: ev, t0: cyc});
    @(posedge clk); #1;
    st[j] = 1'b0;
    wait_done(j);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("rst_busy", 64'(busy_v[j]), 64'd0);
      chk("rst_pvalid", 64'(pv_v[j]), 64'd0);
      chk("rst_pserial", 64'(ps_v[j]), 64'd0);
      chk("rst_done", 64'(done_v[j]), 64'd0);
      chk("rst_product", prod_v[j], 64'd0);
    end
    run_op(0, 32'hFF, 32'hFF, 64'hFE01);
    run_op(1, 32'hFD, 32'h05, 64'hFFF1);
    run_op(1, 32'h80, 32'hFF, 64'h0080);
    run_op(1, 32'h7F, 32'h80, 64'hC080);
    run_op(1, 32'h80, 32'h80, 64'h4000);
    run_op(1, 32'hFF, 32'hFF, 64'h0001);
    run_op(0, 32'h00, 32'hAB, 64'h0000);
    run_op(0, 32'h01, 32'hAB, 64'h00AB);
    // start held high: second operands ignored until accepted in DONE
    @(posedge clk); #1;
    st[0] = 1'b1;
    x_in = 32'd3;
    y_in = 32'd5;
    sb.push_back('{dut: 0, prod: 64'h000F, t0: cyc});
    @(posedge clk); #1;
    x_in = 32'd7;
    y_in = 32'd9;
    repeat (16) @(posedge clk);
    #1 sb.push_back('{dut: 0, prod: 64'h003F, t0: cyc});
    @(posedge clk); #1;
    st[0] = 1'b0;
    wait_done(0);
    // reset during RUN cycle 5
    @(posedge clk); #1;
    st[0] = 1'b1;
    x_in = 32'h12;
    y_in = 32'h34;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy_v[0]), 64'd0);
    chk("abort_product", prod_v[0], 64'd0);
    chk("abort_done", 64'(done_v[0]), 64'd0);
    run_op(0, 32'h12, 32'h34, 64'h03A8);
    run_op(2, 32'hFFFFFFFF, 32'h00000002, 64'h00000001FFFFFFFE);
    run_op(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    run_op(2, 32'h00010000, 32'h00010000, 64'h0000000100000000);
    repeat (5) @(posedge clk);
    #1 chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
